best_sad_sequencer: RTL and testbench

//  Multi-cycle sequencer behind the per-cycle 6-way best-SAD address tree of the FME datapath.

---
 rtl/fme_pkg.sv | 19 +
 rtl/best_sad_compare.sv | 30 +++
 rtl/best_sad_sequencer.sv | 154 +++++++++++++++
 tb/tb_best_sad_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fme_pkg.sv
// Shared types and constants for the FME best-SAD sequencer.
// Holds the candidate geometry, the sequencer state encoding and the address legality helper.
package fme_pkg;

    localparam int CANDS_PER_CYCLE = 6;
    localparam int ADDR_W          = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Address tree only produces 0..5; 6 and 7 mark a corrupted beat.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return (addr < 3'd6);
    endfunction

endpackage

// File: rtl/best_sad_compare.sv
// Combinational running-minimum compare for the best-SAD sequencer.
// Tie policy is selected by FME_TIE_LAST_EN (defined: latest equal candidate wins).
module best_sad_compare #(
    parameter int SAD_W = 16
) (
    input  logic [SAD_W-1:0] sad_in,
    input  logic [SAD_W-1:0] best_sad,
    input  logic             addr_ok,
    output logic             update_en
);

    logic better_s;

    // Candidate beats the current minimum and comes from a legal address.
    always_comb begin
        better_s  = 1'b0;
        update_en = 1'b0;
`ifdef FME_TIE_LAST_EN
        better_s = (sad_in <= best_sad);
`else
        better_s = (sad_in < best_sad);
`endif
        if (addr_ok) begin
            update_en = better_s;
        end else begin
            update_en = 1'b0;
        end
    end

endmodule

// File: rtl/best_sad_sequencer.sv
// Multi-cycle best-SAD sequencer: running minimum over NUM_CYCLES address-tree beats,
// result handed to MV refine over valid/ready. Optional macro: FME_TIE_LAST_EN.
module best_sad_sequencer
    import fme_pkg::*;
#(
    parameter int SAD_W      = 16,
    parameter int NUM_CYCLES = 8,
    localparam int IDX_W     = $clog2(NUM_CYCLES * CANDS_PER_CYCLE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sad_valid,
    output logic              sad_ready,
    input  logic [SAD_W-1:0]  sad_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              best_valid,
    input  logic              best_ready,
    output logic [SAD_W-1:0]  best_sad,
    output logic [IDX_W-1:0]  best_index,
    output logic              busy,
    output logic              err_addr
);

    localparam int CNT_W = (NUM_CYCLES > 1) ? $clog2(NUM_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_CYCLES - 1);

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  beat_cnt_r, beat_cnt_nxt_s;
    logic [SAD_W-1:0]  best_sad_r, best_sad_nxt_s;
    logic [IDX_W-1:0]  best_index_r, best_index_nxt_s;
    logic              err_addr_r, err_addr_nxt_s;
    logic              sad_ready_r, busy_r, best_valid_r;
    logic              addr_ok_s;
    logic              update_en_s;
    logic [IDX_W-1:0]  cnt_ext_s;
    logic [IDX_W-1:0]  cand_index_s;

    assign addr_ok_s = addr_legal(addr_in);

    best_sad_compare #(
        .SAD_W (SAD_W)
    ) u_compare (
        .sad_in    (sad_in),
        .best_sad  (best_sad_r),
        .addr_ok   (addr_ok_s),
        .update_en (update_en_s)
    );

    // Global index = beat*6 + addr, with *6 built as (beat<<2)+(beat<<1).
    always_comb begin
        cnt_ext_s    = IDX_W'(beat_cnt_r);
        cand_index_s = (cnt_ext_s << 2) + (cnt_ext_s << 1) + IDX_W'(addr_in);
    end

    // Next-state and datapath update for the search FSM.
    always_comb begin
        state_nxt_s      = state_r;
        beat_cnt_nxt_s   = beat_cnt_r;
        best_sad_nxt_s   = best_sad_r;
        best_index_nxt_s = best_index_r;
        err_addr_nxt_s   = err_addr_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s      = ACCUM;
                    beat_cnt_nxt_s   = '0;
                    best_sad_nxt_s   = '1;
                    best_index_nxt_s = '0;
                    err_addr_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                // A start here restarts the search and drops this cycle's beat.
                if (start) begin
                    beat_cnt_nxt_s   = '0;
                    best_sad_nxt_s   = '1;
                    best_index_nxt_s = '0;
                    err_addr_nxt_s   = 1'b0;
                end else if (sad_valid) begin
                    if (update_en_s) begin
                        best_sad_nxt_s   = sad_in;
                        best_index_nxt_s = cand_index_s;
                    end else begin
                        best_sad_nxt_s = best_sad_r;
                    end
                    if (!addr_ok_s) begin
                        err_addr_nxt_s = 1'b1;
                    end else begin
                        err_addr_nxt_s = err_addr_r;
                    end
                    if (beat_cnt_r == LAST_BEAT) begin
                        state_nxt_s = HOLD;
                    end else begin
                        beat_cnt_nxt_s = beat_cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            HOLD: begin
                if (best_ready) begin
                    if (start) begin
                        state_nxt_s      = ACCUM;
                        beat_cnt_nxt_s   = '0;
                        best_sad_nxt_s   = '1;
                        best_index_nxt_s = '0;
                        err_addr_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and handshake output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            beat_cnt_r   <= '0;
            best_sad_r   <= '1;
            best_index_r <= '0;
            err_addr_r   <= 1'b0;
            sad_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
            best_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            beat_cnt_r   <= beat_cnt_nxt_s;
            best_sad_r   <= best_sad_nxt_s;
            best_index_r <= best_index_nxt_s;
            err_addr_r   <= err_addr_nxt_s;
            sad_ready_r  <= (state_nxt_s == ACCUM);
            busy_r       <= (state_nxt_s != IDLE);
            best_valid_r <= (state_nxt_s == HOLD);
        end
    end

    assign sad_ready  = sad_ready_r;
    assign busy       = busy_r;
    assign best_valid = best_valid_r;
    assign best_sad   = best_sad_r;
    assign best_index = best_index_r;
    assign err_addr   = err_addr_r;

endmodule

// File: tb/tb_best_sad_sequencer.sv
// Scoreboard bench for best_sad_sequencer: stimulus pushes hand-computed results,
// a monitor pops and compares on every best_valid&best_ready handshake.
module tb_best_sad_sequencer;

    localparam int SAD_W = 16;
    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sad_valid;
    logic             sad_ready;
    logic [SAD_W-1:0] sad_in;
    logic [2:0]       addr_in;
    logic             best_valid;
    logic             best_ready;
    logic [SAD_W-1:0] best_sad;
    logic [IDX_W-1:0] best_index;
    logic             busy;
    logic             err_addr;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [IDX_W-1:0] idx;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    best_sad_sequencer #(.SAD_W(SAD_W), .NUM_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sad_valid  (sad_valid),
        .sad_ready  (sad_ready),
        .sad_in     (sad_in),
        .addr_in    (addr_in),
        .best_valid (best_valid),
        .best_ready (best_ready),
        .best_sad   (best_sad),
        .best_index (best_index),
        .busy       (busy),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [SAD_W-1:0] s, input logic [2:0] a);
        sad_valid = 1'b1;
        sad_in    = s;
        addr_in   = a;
        tick();
        sad_valid = 1'b0;
    endtask

    // Eight beats; best_valid must stay low after beat 7 and rise right after beat 8.
    task automatic block(input logic [8*SAD_W-1:0] sads, input logic [23:0] addrs);
        for (int i = 0; i < 8; i++) begin
            beat(sads[(7-i)*SAD_W +: SAD_W], addrs[(7-i)*3 +: 3]);
            if (i == 6) chk("valid_before_last", best_valid, 0);
        end
        chk("valid_after_last", best_valid, 1);
        chk("ready_in_hold", sad_ready, 0);
    endtask

    task automatic collect();
        best_ready = 1'b1;
        tick();
        best_ready = 1'b0;
        chk("idle_after_handshake", busy, 0);
    endtask

    task automatic push(input logic [SAD_W-1:0] s, input logic [IDX_W-1:0] i, input logic e);
        exp_t x;
        x.sad = s;
        x.idx = i;
        x.err = e;
        exp_q.push_back(x);
    endtask

    // Monitor: compare each accepted result against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && best_valid && best_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("best_sad", best_sad, e.sad);
                chk("best_index", best_index, e.idx);
                chk("err_addr", err_addr, e.err);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; sad_valid = 1'b0; sad_in = '0; addr_in = '0; best_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", best_valid, 0);
        chk("rst_sad", best_sad, 16'hFFFF);
        chk("rst_busy", busy, 0);
        chk("rst_ready", sad_ready, 0);
        chk("rst_index", best_index, 0);

        // Beats outside ACCUM are ignored.
        beat(16'd3, 3'd1);
        chk("idle_ready", sad_ready, 0);
        chk("idle_busy", busy, 0);

        // Basic search: min 35 at beat 3 addr 2 -> 20.
        start = 1'b1; tick(); start = 1'b0;
        chk("accum_ready", sad_ready, 1);
        push(16'd35, 6'd20, 1'b0);
        block({16'd90, 16'd80, 16'd70, 16'd35, 16'd60, 16'd50, 16'd40, 16'd45},
              {3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2});
        collect();

        // Tie between beats 0 and 5.
        start = 1'b1; tick(); start = 1'b0;
`ifdef FME_TIE_LAST_EN
        push(16'd10, 6'd31, 1'b0);
`else
        push(16'd10, 6'd1, 1'b0);
`endif
        block({16'd10, 16'd50, 16'd50, 16'd50, 16'd50, 16'd10, 16'd50, 16'd50},
              {3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1});
        collect();

        // Illegal address on beat 3 carrying SAD 0: counted, not compared.
        start = 1'b1; tick(); start = 1'b0;
        push(16'd5, 6'd30, 1'b1);
        block({16'd9, 16'd8, 16'd7, 16'd0, 16'd6, 16'd5, 16'd12, 16'd11},
              {3'd0, 3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0});
        collect();

        // Back-pressure: hold 5 clks, stray start ignored, then handshake with start.
        start = 1'b1; tick(); start = 1'b0;
        chk("err_cleared", err_addr, 0);
        push(16'd3, 6'd47, 1'b0);
        block({16'd20, 16'd19, 16'd18, 16'd17, 16'd16, 16'd15, 16'd14, 16'd3},
              {3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5});
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            chk("hold_valid", best_valid, 1);
            chk("hold_sad", best_sad, 3);
            chk("hold_index", best_index, 47);
            chk("hold_ready", sad_ready, 0);
        end
        best_ready = 1'b1; start = 1'b1;
        tick();
        best_ready = 1'b0; start = 1'b0;
        chk("restart_valid", best_valid, 0);
        chk("restart_busy", busy, 1);
        chk("restart_ready", sad_ready, 1);

        // Abort by start after 4 beats; the beat with the start is discarded.
        for (int i = 0; i < 4; i++) beat(16'd1, 3'd0);
        start = 1'b1; sad_valid = 1'b1; sad_in = 16'd0; addr_in = 3'd0;
        tick();
        start = 1'b0; sad_valid = 1'b0;
        push(16'd20, 6'd16, 1'b0);
        block({16'd40, 16'd30, 16'd20, 16'd25, 16'd35, 16'd45, 16'd22, 16'd21},
              {3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4});
        collect();

        // Reset after 4 beats; then an all-ones block.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) beat(16'd2, 3'd1);
        rst = 1'b1; #2; rst = 1'b0;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_sad", best_sad, 16'hFFFF);
        chk("midrst_index", best_index, 0);
        start = 1'b1; tick(); start = 1'b0;
`ifdef FME_TIE_LAST_EN
        push(16'hFFFF, 6'd45, 1'b0);
`else
        push(16'hFFFF, 6'd0, 1'b0);
`endif
        block({8{16'hFFFF}}, {8{3'd3}});
        collect();

        tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
